rr_demux_sched: RTL

- Round-robin scheduler that shares a single 1-to-4 decoder/demux path between four requesters.
- Each requester gets exclusive tenure of the path.
- The block arbitrates, registers a 2-bit select, and routes the serial input bit to the owning channel's output.
- Tenure ends when the owner drops its request, or is preempted after a bounded hold time if other requesters are waiting.

---
 rtl/rr_demux_sched_if.sv | 22 ++
 rtl/rr_demux_sched.sv | 127 ++++++++++++
 2 files changed

// File: rtl/rr_demux_sched_if.sv
// Interface for the round-robin demux scheduler: request/enable/data inputs and
// the registered grant view plus the steered output bits.
interface rr_demux_sched_if;
    logic       i_en;
    logic [0:3] i_req;
    logic       i_in;
    logic [0:3] o_gnt;
    logic [0:1] o_sel;
    logic       o_busy;
    logic       o_preempt;
    logic [0:3] o_out;

    modport master (
        output i_en, i_req, i_in,
        input  o_gnt, o_sel, o_busy, o_preempt, o_out
    );

    modport slave (
        input  i_en, i_req, i_in,
        output o_gnt, o_sel, o_busy, o_preempt, o_out
    );
endinterface

// File: rtl/rr_demux_sched.sv
// Round-robin owner of a shared 1-to-4 demux path: grants exclusive tenure,
// rotates on release or after MAX_HOLD cycles when others wait, steers i_in to the owner.
module rr_demux_sched #(
    parameter int MAX_HOLD = 8,
    parameter int CW       = 8
) (
    input  logic            clk,
    input  logic            rst,
    rr_demux_sched_if.slave bus
);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);

    state_t        r_state;
    logic [0:3]    r_gnt;
    logic [0:1]    r_sel;
    logic          r_busy;
    logic          r_preempt;
    logic [1:0]    r_ptr;
    logic [CW-1:0] r_cnt;

    logic [0:3]    w_others;
    logic          w_timeout;
    logic          w_take;
    logic          w_to_idle;
    logic          w_preempt_edge;
    logic [1:0]    w_new_owner;
    logic [0:3]    w_new_gnt;
    logic [0:3]    w_out;

    // First set bit of mask, searching upward from start with wrap-around.
    function automatic logic [1:0] pick(input logic [0:3] mask, input logic [1:0] start);
        logic [1:0] idx;
        logic       found;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && mask[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_others         = bus.i_req;
        w_others[r_sel]  = 1'b0;
        w_timeout        = (MAX_HOLD != 0) && (r_cnt == HOLD_LAST) && (|w_others) && bus.i_en;
        w_take           = 1'b0;
        w_to_idle        = 1'b0;
        w_preempt_edge   = 1'b0;
        w_new_owner      = r_sel;
        case (r_state)
            S_IDLE: begin
                if (bus.i_en && (|bus.i_req)) begin
                    w_take      = 1'b1;
                    w_new_owner = pick(bus.i_req, r_ptr);
                end
            end
            S_GRANT: begin
                // The outgoing owner is masked out, so it never wins twice in a row.
                if (!bus.i_req[r_sel]) begin
                    if (bus.i_en && (|w_others)) begin
                        w_take      = 1'b1;
                        w_new_owner = pick(w_others, r_sel + 2'd1);
                    end else begin
                        w_to_idle = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_take         = 1'b1;
                    w_preempt_edge = 1'b1;
                    w_new_owner    = pick(w_others, r_sel + 2'd1);
                end
            end
            default: ;
        endcase
        w_new_gnt              = '0;
        w_new_gnt[w_new_owner] = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_sel     <= '0;
            r_busy    <= 1'b0;
            r_preempt <= 1'b0;
            r_ptr     <= '0;
            r_cnt     <= '0;
        end else begin
            r_preempt <= w_preempt_edge;
            if (w_take) begin
                r_state <= S_GRANT;
                r_gnt   <= w_new_gnt;
                r_sel   <= w_new_owner;
                r_busy  <= 1'b1;
                r_ptr   <= w_new_owner + 2'd1;
                r_cnt   <= '0;
            end else if (w_to_idle) begin
                r_state <= S_IDLE;
                r_gnt   <= '0;
                r_busy  <= 1'b0;
            end else if (r_state == S_GRANT && r_cnt != HOLD_LAST) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        w_out = '0;
        if (r_busy) begin
            w_out[r_sel] = bus.i_in;
        end
    end

    assign bus.o_gnt     = r_gnt;
    assign bus.o_sel     = r_sel;
    assign bus.o_busy    = r_busy;
    assign bus.o_preempt = r_preempt;
    assign bus.o_out     = w_out;

endmodule
